// File: rtl/timer_sequencer.sv
// -----------------------------------------------------------------------------
// timer_sequencer
//
// Programmable periodic timer controller. A prescaler counting 0..presc feeds
// its carry into a period counter counting 0..period. Every time the period
// counter completes a full period a registered one-cycle tick is produced.
// A start/pause/stop FSM gates counting, an optional repeat limit stops the
// timer automatically (with a done pulse), and a valid/ready handshake loads
// the configuration while the timer is idle.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   cfg_valid     config write request
//   cfg_ready     high while IDLE; config loads when cfg_valid & cfg_ready
//   cfg_presc     prescaler max (divide by presc+1)
//   cfg_period    period max (period+1 prescaled steps per period)
//   cfg_repeat    periods before auto-stop, 0 = run forever
//   start         start from IDLE / resume from PAUSE
//   pause         freeze counting while running
//   stop          abort to IDLE from any state, no done
//   busy          state != IDLE
//   state         IDLE=0, RUN=1, PAUSE=2
//   tick          one-cycle pulse per completed period
//   done          one-cycle pulse when the repeat limit is reached
//   cnt           current period count
//   rep_cnt       completed periods since the last start
// -----------------------------------------------------------------------------
module timer_sequencer #(
    parameter int DW = 16,
    parameter int PW = 8,
    parameter int RW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [PW-1:0] cfg_presc,
    input  logic [DW-1:0] cfg_period,
    input  logic [RW-1:0] cfg_repeat,
    input  logic          start,
    input  logic          pause,
    input  logic          stop,
    output logic          busy,
    output logic [1:0]    state,
    output logic          tick,
    output logic          done,
    output logic [DW-1:0] cnt,
    output logic [RW-1:0] rep_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_cnt_q, presc_cnt_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          tick_q, tick_d;
    logic          done_q, done_d;

    logic [PW-1:0] presc_q;
    logic [DW-1:0] period_q;
    logic [RW-1:0] repeat_q;

    logic          cfg_accept;
    logic          count_en;
    logic          carry;
    logic          wrap;
    logic          last_wrap;
    logic [RW-1:0] rep_inc;

    assign cfg_ready  = (state_q == ST_IDLE);
    assign cfg_accept = cfg_valid & cfg_ready;

    // Counting only happens in RUN, and both pause and stop take priority
    // over the count (a pause on the final-wrap cycle suppresses that wrap).
    assign count_en  = (state_q == ST_RUN) & ~pause & ~stop;
    assign carry     = count_en & ~(presc_cnt_q < presc_q);
    assign wrap      = carry & (cnt_q == period_q);
    assign rep_inc   = rep_cnt_q + 1'b1;
    assign last_wrap = wrap & (repeat_q != '0) & (rep_inc == repeat_q);

    // -------------------------------------------------------------------------
    // Configuration registers: only writable while idle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q  <= '0;
            period_q <= '0;
            repeat_q <= '0;
        end else if (cfg_accept) begin
            presc_q  <= cfg_presc;
            period_q <= cfg_period;
            repeat_q <= cfg_repeat;
        end
    end

    // -------------------------------------------------------------------------
    // State and counter registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            presc_cnt_q <= '0;
            cnt_q       <= '0;
            rep_cnt_q   <= '0;
            tick_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_cnt_q <= presc_cnt_d;
            cnt_q       <= cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            tick_q      <= tick_d;
            done_q      <= done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic. Priority: stop > pause > start > wrap.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        presc_cnt_d = presc_cnt_q;
        cnt_d       = cnt_q;
        rep_cnt_d   = rep_cnt_q;
        // The pulses are registered versions of this cycle's wrap, so a
        // tick earned in the cycle before a stop still appears.
        tick_d      = wrap;
        done_d      = last_wrap;

        if (stop) begin
            // rep_cnt is kept so software can see how far the run got.
            state_d     = ST_IDLE;
            presc_cnt_d = '0;
            cnt_d       = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d     = ST_RUN;
                        presc_cnt_d = '0;
                        cnt_d       = '0;
                        rep_cnt_d   = '0;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSE;
                    end else begin
                        if (presc_cnt_q < presc_q) begin
                            presc_cnt_d = presc_cnt_q + 1'b1;
                        end else begin
                            presc_cnt_d = '0;
                        end
                        if (carry) begin
                            if (cnt_q < period_q) begin
                                cnt_d = cnt_q + 1'b1;
                            end else begin
                                cnt_d = '0;
                            end
                        end
                        if (wrap) begin
                            // With repeat=0 this simply rolls over.
                            rep_cnt_d = rep_inc;
                        end
                        if (last_wrap) begin
                            // Counters are already 0 after the wrap, so only
                            // the state needs to change.
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_PAUSE: begin
                    // pause outranks start, so a held pause keeps us frozen.
                    if (start && !pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign state   = state_q;
    assign tick    = tick_q;
    assign done    = done_q;
    assign cnt     = cnt_q;
    assign rep_cnt = rep_cnt_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_timer_sequencer
//
// Directed bench for timer_sequencer. A behavioural model tracks the timer as
// "number of counted steps in the current period chain"; the period count is
// derived from that by division and a wrap is simply step number L=(p+1)(q+1).
// Outputs are compared against the model on every falling edge, and literal
// cycle-exact expectations are checked along the way.
// -----------------------------------------------------------------------------
module tb_timer_sequencer;

    localparam int DW = 16;
    localparam int PW = 8;
    localparam int RW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [PW-1:0] cfg_presc = '0;
    logic [DW-1:0] cfg_period = '0;
    logic [RW-1:0] cfg_repeat = '0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic          stop = 1'b0;
    logic          busy;
    logic [1:0]    state;
    logic          tick;
    logic          done;
    logic [DW-1:0] cnt;
    logic [RW-1:0] rep_cnt;

    timer_sequencer #(.DW(DW), .PW(PW), .RW(RW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_presc  (cfg_presc),
        .cfg_period (cfg_period),
        .cfg_repeat (cfg_repeat),
        .start      (start),
        .pause      (pause),
        .stop       (stop),
        .busy       (busy),
        .state      (state),
        .tick       (tick),
        .done       (done),
        .cnt        (cnt),
        .rep_cnt    (rep_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------------
    typedef struct {
        int st;      // 0 idle, 1 run, 2 pause
        int steps;   // counted steps inside the current period
        int rep;
        int presc;
        int period;
        int rpt;
        bit tick;
        bit done;
    } model_t;

    model_t m = '{default: 0};

    function automatic model_t step(input model_t c, input bit st_i, input bit pa_i,
                                    input bit sp_i, input bit cv_i, input int cp,
                                    input int cper, input int crep);
        model_t n;
        int  len;
        bit  en;
        bit  wr;
        bit  last;
        n    = c;
        len  = (c.presc + 1) * (c.period + 1);
        en   = (c.st == 1) && !pa_i && !sp_i;
        wr   = en && (c.steps + 1 == len);
        last = wr && (c.rpt != 0) && (((c.rep + 1) % 256) == c.rpt);
        n.tick = wr;
        n.done = last;
        if (sp_i) begin
            n.st = 0;
            n.steps = 0;
        end else if (c.st == 0 && st_i) begin
            n.st = 1;
            n.steps = 0;
            n.rep = 0;
        end else if (c.st == 1 && pa_i) begin
            n.st = 2;
        end else if (en) begin
            n.steps = wr ? 0 : c.steps + 1;
            if (wr) begin
                n.rep = (c.rep + 1) % 256;
                if (last) n.st = 0;
            end
        end else if (c.st == 2 && st_i && !pa_i) begin
            n.st = 1;
        end
        if (cv_i && c.st == 0) begin
            n.presc  = cp;
            n.period = cper;
            n.rpt    = crep;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{default: 0};
        else m <= step(m, start, pause, stop, cfg_valid, int'(cfg_presc),
                       int'(cfg_period), int'(cfg_repeat));
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("state",     32'(state),     32'(m.st));
        chk("busy",      32'(busy),      32'(m.st != 0));
        chk("cfg_ready", 32'(cfg_ready), 32'(m.st == 0));
        chk("tick",      32'(tick),      32'(m.tick));
        chk("done",      32'(done),      32'(m.done));
        chk("cnt",       32'(cnt),       32'(m.steps / (m.presc + 1)));
        chk("rep_cnt",   32'(rep_cnt),   32'(m.rep));
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (all called at a falling edge)
    // ------------------------------------------------------------------------
    task automatic at_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic do_cfg(input int p, input int per, input int rp, input bit with_start);
        cfg_presc  = PW'(p);
        cfg_period = DW'(per);
        cfg_repeat = RW'(rp);
        cfg_valid  = 1'b1;
        start      = with_start;
        @(negedge clk);
        cfg_valid  = 1'b0;
        start      = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    int t0;

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(state), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cfg_ready", 32'(cfg_ready), 1);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_cnt", 32'(cnt), 0);
        chk("rst_rep", 32'(rep_cnt), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: presc=1 period=2 repeat=2 -> ticks at 7 and 13, done at 13
        do_cfg(1, 2, 2, 1'b0);
        t0 = cyc;
        pulse_start();
        at_cycle(t0 + 6);
        chk("t1_tick6", 32'(tick), 0);
        at_cycle(t0 + 7);
        chk("t1_tick7", 32'(tick), 1);
        chk("t1_done7", 32'(done), 0);
        at_cycle(t0 + 13);
        chk("t1_tick13", 32'(tick), 1);
        chk("t1_done13", 32'(done), 1);
        chk("t1_busy13", 32'(busy), 0);
        chk("t1_rep13", 32'(rep_cnt), 2);
        at_cycle(t0 + 14);
        chk("t1_done14", 32'(done), 0);

        // T2: degenerate config, tick every cycle, rep_cnt rolls over
        do_cfg(0, 0, 0, 1'b0);
        t0 = cyc;
        pulse_start();
        chk("t2_tick1", 32'(tick), 0);
        at_cycle(t0 + 2);
        chk("t2_tick2", 32'(tick), 1);
        at_cycle(t0 + 256);
        chk("t2_rep255", 32'(rep_cnt), 255);
        at_cycle(t0 + 257);
        chk("t2_rep_wrap", 32'(rep_cnt), 0);
        at_cycle(t0 + 260);
        chk("t2_tick260", 32'(tick), 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("t2_stop_state", 32'(state), 0);
        chk("t2_stop_done", 32'(done), 0);
        chk("t2_stop_tick", 32'(tick), 0);
        chk("t2_stop_rep", 32'(rep_cnt), 3);

        // T3: pause held cycles 5..9, resume at 10 -> tick at 27 instead of 21
        do_cfg(3, 4, 1, 1'b0);
        t0 = cyc;
        pulse_start();
        at_cycle(t0 + 5);
        pause = 1'b1;
        at_cycle(t0 + 8);
        chk("t3_pause_state", 32'(state), 2);
        chk("t3_pause_cnt", 32'(cnt), 1);
        at_cycle(t0 + 10);
        pause = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        at_cycle(t0 + 21);
        chk("t3_tick21", 32'(tick), 0);
        at_cycle(t0 + 26);
        chk("t3_tick26", 32'(tick), 0);
        at_cycle(t0 + 27);
        chk("t3_tick27", 32'(tick), 1);
        chk("t3_done27", 32'(done), 1);

        // T4: config ignored while running, then cfg_valid+start together
        do_cfg(1, 1, 3, 1'b0);
        t0 = cyc;
        pulse_start();
        at_cycle(t0 + 3);
        cfg_presc  = 8'd5;
        cfg_period = 16'd7;
        cfg_repeat = 8'd1;
        cfg_valid  = 1'b1;
        chk("t4_cfg_ready_run", 32'(cfg_ready), 0);
        @(negedge clk);
        cfg_valid  = 1'b0;
        at_cycle(t0 + 9);
        chk("t4_tick9", 32'(tick), 1);
        at_cycle(t0 + 13);
        chk("t4_done13", 32'(done), 1);
        chk("t4_rep13", 32'(rep_cnt), 3);
        t0 = cyc;
        do_cfg(2, 1, 1, 1'b1);
        at_cycle(t0 + 6);
        chk("t4b_tick6", 32'(tick), 0);
        at_cycle(t0 + 7);
        chk("t4b_tick7", 32'(tick), 1);
        chk("t4b_done7", 32'(done), 1);

        // T5: pause on the final-wrap cycle, then resume
        do_cfg(1, 1, 1, 1'b0);
        t0 = cyc;
        pulse_start();
        at_cycle(t0 + 4);
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        chk("t5_state_pause", 32'(state), 2);
        chk("t5_no_tick", 32'(tick), 0);
        chk("t5_no_done", 32'(done), 0);
        at_cycle(t0 + 6);
        pulse_start();
        chk("t5_tick7", 32'(tick), 0);
        at_cycle(t0 + 8);
        chk("t5_tick8", 32'(tick), 1);
        chk("t5_done8", 32'(done), 1);
        chk("t5_idle8", 32'(state), 0);

        // stop+start in IDLE stays IDLE
        stop  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        stop  = 1'b0;
        start = 1'b0;
        chk("stop_start_idle", 32'(state), 0);

        // T6: asynchronous reset mid-run, config lost afterwards
        do_cfg(0, 3, 0, 1'b0);
        t0 = cyc;
        pulse_start();
        at_cycle(t0 + 6);
        chk("t6_cnt", 32'(cnt), 1);
        chk("t6_rep", 32'(rep_cnt), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_state", 32'(state), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_ready", 32'(cfg_ready), 1);
        chk("t6_rst_cnt", 32'(cnt), 0);
        chk("t6_rst_rep", 32'(rep_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        t0 = cyc;
        pulse_start();
        chk("t6_post_tick1", 32'(tick), 0);
        at_cycle(t0 + 2);
        chk("t6_post_tick2", 32'(tick), 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got cyc %0d expected < 20000", cyc);
        $fatal(1);
    end

endmodule
